// File: rtl/bus_timeout_pkg.sv
// bus_timeout_pkg: shared state encoding and default abort fill data
package bus_timeout_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_e;
  localparam logic [31:0] DEFAULT_FILL = 32'hdeadbeef;
endpackage

// File: rtl/if_wb.sv
// if_wb: pipelined Wishbone bus bundle with master/slave views
interface if_wb #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          cyc, stb, we, ack, stall;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
`ifdef NO_MODPORT_EXPRESSIONS
  logic [DW-1:0] dat_m, dat_s;
  modport master(output cyc, stb, we, adr, sel, dat_m, input ack, stall, dat_s);
  modport slave(input cyc, stb, we, adr, sel, dat_m, output ack, stall, dat_s);
`else
  logic [DW-1:0] dat_i, dat_o;
  modport master(output cyc, stb, we, adr, sel, dat_i, input ack, stall, dat_o);
  modport slave(input cyc, stb, we, adr, sel, dat_i, output ack, stall, dat_o);
`endif
endinterface

// File: rtl/bus_timeout_timer.sv
// bus_timeout_timer: counts quiet busy cycles and flags when the abort threshold is reached
module bus_timeout_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  assign expired_o = cnt_q == TW'(TIMEOUT - 1);
  assign cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + TW'(1) : cnt_q;
  // quiet-cycle counter, held once expired until cleared
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bus_timeout.sv
// bus_timeout: Wishbone watchdog that aborts silent transactions with synthetic acks
module bus_timeout
  import bus_timeout_pkg::*;
#(
  parameter int          TIMEOUT = 256,
  parameter int          MAXOUT  = 4,
  parameter logic [31:0] FILL    = DEFAULT_FILL
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        up,
  if_wb.master       down,
  output logic       timeout_o,
  output logic [7:0] err_count_o
);
  state_e     state_q, state_d;
  logic [3:0] out_q, out_d;
  logic [7:0] err_q, err_d;
  logic       flush, full, accept, ack_ok, syn_ack, expired;
  assign flush      = state_q == FLUSH;
  assign full       = out_q == 4'(MAXOUT);
  assign down.adr   = up.adr;
  assign down.we    = up.we;
  assign down.sel   = up.sel;
  assign down.cyc   = up.cyc & !flush;
  assign down.stb   = up.stb & !full & !flush;
  assign up.stall   = down.stall | full | flush;
  assign accept     = up.cyc & up.stb & !up.stall;
  assign ack_ok     = down.ack & !flush & (out_q != '0);
  assign syn_ack    = flush & up.cyc & (out_q != '0);
  assign up.ack     = ack_ok | syn_ack;
  assign timeout_o  = (state_q == BUSY) & up.cyc & !down.ack & expired;
  assign err_count_o = err_q;
`ifdef NO_MODPORT_EXPRESSIONS
  assign down.dat_m = up.dat_m;
  assign up.dat_s   = flush ? FILL : down.dat_s;
`else
  assign down.dat_i = up.dat_i;
  assign up.dat_o   = flush ? FILL : down.dat_o;
`endif
  bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i,
    .rst_i,
    .clr_i    ((state_q != BUSY) | down.ack | !up.cyc),
    .en_i     (state_q == BUSY),
    .expired_o(expired)
  );
  // next outstanding count, state and saturating abort count; a master abort wins over everything
  always_comb begin
    out_d   = !up.cyc ? '0 : flush ? out_q - 4'(syn_ack) : out_q + 4'(accept) - 4'(ack_ok);
    state_d = !up.cyc ? IDLE : flush ? (out_q <= 4'd1 ? IDLE : FLUSH) : timeout_o ? FLUSH : (out_d != '0 ? BUSY : IDLE);
    err_d   = err_q + 8'(timeout_o && err_q != 8'hff);
  end
  // state registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_bus_timeout.sv
// tb_bus_timeout: vector table, directed corner sequences and randomized model check of bus_timeout
module tb_bus_timeout;
  localparam logic [31:0] FILL = 32'hdeadbeef;
  logic clk = 0, rst_n = 0, tmo;
  logic [7:0] errc;
  logic [31:0] m_wdat, s_rdat, up_rdat, dn_wdat;
  int vecs = 0, bad = 0, pulses = 0;
  if_wb up_if();
  if_wb dn_if();
`ifdef NO_MODPORT_EXPRESSIONS
  assign up_if.dat_m = m_wdat;
  assign dn_if.dat_s = s_rdat;
  assign up_rdat = up_if.dat_s;
  assign dn_wdat = dn_if.dat_m;
`else
  assign up_if.dat_i = m_wdat;
  assign dn_if.dat_o = s_rdat;
  assign up_rdat = up_if.dat_o;
  assign dn_wdat = dn_if.dat_i;
`endif
  bus_timeout #(.TIMEOUT(8), .MAXOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .up(up_if), .down(dn_if), .timeout_o(tmo), .err_count_o(errc)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (tmo) pulses++;

  typedef struct {
    logic cyc, stb, we; logic [31:0] adr; logic [3:0] sel; logic [31:0] wd;
    logic dstall, dack; logic [31:0] rd;
    logic e_cyc, e_stb, e_stall, e_ack;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    up_if.cyc = 0; up_if.stb = 0; up_if.we = 0; dn_if.ack = 0; dn_if.stall = 0;
  endtask
  task automatic mset(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
    up_if.cyc = c; up_if.stb = s; up_if.we = w; up_if.adr = a; up_if.sel = sl; m_wdat = d;
  endtask

  initial begin
    int p0, e0, pend, quiet, errs;
    bit fl, full, e_stall, acc, ackok, syn, tm;
    idle(); up_if.adr = 0; up_if.sel = 0; m_wdat = 0; s_rdat = 0;
    #3;
    chk("rst_timeout", 32'(tmo), 0);
    chk("rst_errc", 32'(errc), 0);
    chk("rst_up_ack", 32'(up_if.ack), 0);
    chk("rst_dn_cyc", 32'(dn_if.cyc), 0);
    chk("rst_up_stall", 32'(up_if.stall), 0);
    @(negedge clk); rst_n = 1;
    step();
    // combinational pass-through vectors from IDLE
    tbl[0] = '{1, 1, 0, 32'h0000_1000, 4'hf, 32'h0, 0, 0, 32'h1111_2222, 1, 1, 0, 0};
    tbl[1] = '{1, 1, 1, 32'ha5a5_a5a4, 4'h3, 32'hcafe_f00d, 1, 0, 32'h0, 1, 1, 1, 0};
    tbl[2] = '{0, 0, 0, 32'h0000_0008, 4'h1, 32'h0, 0, 1, 32'h7777_0000, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 32'hffff_fffc, 4'h8, 32'h0123_4567, 0, 1, 32'h89ab_cdef, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 32'h0000_0040, 4'hc, 32'h5a5a_5a5a, 1, 0, 32'h0, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      mset(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd);
      dn_if.stall = tbl[i].dstall; dn_if.ack = tbl[i].dack; s_rdat = tbl[i].rd;
      #1;
      chk("tbl_adr", dn_if.adr, tbl[i].adr);
      chk("tbl_we", 32'(dn_if.we), 32'(tbl[i].we));
      chk("tbl_sel", 32'(dn_if.sel), 32'(tbl[i].sel));
      chk("tbl_wdat", dn_wdat, tbl[i].wd);
      chk("tbl_rdat", up_rdat, tbl[i].rd);
      chk("tbl_dn_cyc", 32'(dn_if.cyc), 32'(tbl[i].e_cyc));
      chk("tbl_dn_stb", 32'(dn_if.stb), 32'(tbl[i].e_stb));
      chk("tbl_up_stall", 32'(up_if.stall), 32'(tbl[i].e_stall));
      chk("tbl_up_ack", 32'(up_if.ack), 32'(tbl[i].e_ack));
      step(); idle(); step();
    end
    // single read acked two cycles later
    p0 = pulses;
    mset(1, 1, 0, 32'h40, 4'hf, 0); #1;
    chk("rd_dn_stb", 32'(dn_if.stb), 1);
    step(); up_if.stb = 0; #1;
    chk("rd_wait_ack", 32'(up_if.ack), 0);
    step(); dn_if.ack = 1; s_rdat = 32'h1234_5678; #1;
    chk("rd_up_ack", 32'(up_if.ack), 1);
    chk("rd_up_dat", up_rdat, 32'h1234_5678);
    step(); idle(); #1;
    chk("rd_ack_done", 32'(up_if.ack), 0);
    step();
    chk("rd_no_timeout", 32'(pulses - p0), 0);
    // back-pressure once four transfers are outstanding
    mset(1, 1, 1, 32'h80, 4'hf, 32'h11);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_dn_stb", 32'(dn_if.stb), 1);
      chk("bp_up_stall", 32'(up_if.stall), 0);
      step();
    end
    #1;
    chk("bp_full_stall", 32'(up_if.stall), 1);
    chk("bp_full_stb", 32'(dn_if.stb), 0);
    step(); #1;
    chk("bp_still_stall", 32'(up_if.stall), 1);
    chk("bp_still_stb", 32'(dn_if.stb), 0);
    idle(); step();
    // silent slave: abort and flush two synthetic acks
    mset(1, 1, 0, 32'h100, 4'hf, 0);
    step();
    for (int i = 1; i < 8; i++) begin
      if (i == 2) up_if.stb = 0;
      #1;
      chk("to_early", 32'(tmo), 0);
      step();
    end
    #1;
    chk("to_pulse", 32'(tmo), 1);
    chk("to_dn_cyc_busy", 32'(dn_if.cyc), 1);
    step(); dn_if.ack = 1; s_rdat = 32'h5555_5555; #1;
    chk("fl_ack1", 32'(up_if.ack), 1);
    chk("fl_dat1", up_rdat, FILL);
    chk("fl_dn_cyc", 32'(dn_if.cyc), 0);
    chk("fl_stall", 32'(up_if.stall), 1);
    chk("fl_errc", 32'(errc), 1);
    chk("fl_to_once", 32'(tmo), 0);
    step(); dn_if.ack = 0; #1;
    chk("fl_ack2", 32'(up_if.ack), 1);
    chk("fl_dat2", up_rdat, FILL);
    step(); #1;
    chk("fl_done_ack", 32'(up_if.ack), 0);
    chk("fl_idle_cyc", 32'(dn_if.cyc), 1);
    chk("fl_idle_stall", 32'(up_if.stall), 0);
    idle(); step();
    // accept and ack together: count held, timer restarted
    mset(1, 1, 0, 32'h200, 4'hf, 0);
    step(); up_if.stb = 0;
    repeat (4) step();
    up_if.stb = 1; dn_if.ack = 1; s_rdat = 32'h0000_abcd; #1;
    chk("sim_up_ack", 32'(up_if.ack), 1);
    chk("sim_dn_stb", 32'(dn_if.stb), 1);
    step(); up_if.stb = 0; dn_if.ack = 0;
    for (int i = 6; i < 13; i++) begin
      #1;
      chk("sim_to_early", 32'(tmo), 0);
      step();
    end
    #1;
    chk("sim_to_pulse", 32'(tmo), 1);
    step(); #1;
    chk("sim_fl_ack", 32'(up_if.ack), 1);
    step(); #1;
    chk("sim_one_ack", 32'(up_if.ack), 0);
    chk("sim_errc", 32'(errc), 2);
    idle(); step();
    // master abort with three outstanding
    e0 = errc; p0 = pulses;
    mset(1, 1, 0, 32'h300, 4'hf, 0);
    repeat (3) step();
    up_if.stb = 0;
    step(); up_if.cyc = 0; #1;
    chk("ab_dn_cyc", 32'(dn_if.cyc), 0);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("ab_no_ack", 32'(up_if.ack), 0);
    end
    chk("ab_errc", 32'(errc), 32'(e0));
    chk("ab_no_timeout", 32'(pulses - p0), 0);
    mset(1, 1, 0, 32'h340, 4'hf, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ab_cleared_stb", 32'(dn_if.stb), 1);
      step();
    end
    idle(); step();
    // reset asserted mid-flush
    mset(1, 1, 0, 32'h400, 4'hf, 0);
    repeat (3) step();
    up_if.stb = 0;
    repeat (6) step();
    #1;
    chk("rf_fl_ack", 32'(up_if.ack), 1);
    chk("rf_fl_dat", up_rdat, FILL);
    step(); rst_n = 0; up_if.cyc = 0; #1;
    chk("rf_timeout", 32'(tmo), 0);
    chk("rf_errc", 32'(errc), 0);
    chk("rf_up_ack", 32'(up_if.ack), 0);
    chk("rf_dn_cyc", 32'(dn_if.cyc), 0);
    chk("rf_dn_stb", 32'(dn_if.stb), 0);
    chk("rf_stall", 32'(up_if.stall), 0);
    step(); #1;
    chk("rf_held_ack", 32'(up_if.ack), 0);
    @(negedge clk); rst_n = 1;
    step();
    mset(1, 1, 0, 32'h500, 4'hf, 0); #1;
    chk("rf_rd_stb", 32'(dn_if.stb), 1);
    step(); up_if.stb = 0; dn_if.ack = 1; s_rdat = 32'h0bad_f00d; #1;
    chk("rf_rd_ack", 32'(up_if.ack), 1);
    chk("rf_rd_dat", up_rdat, 32'h0bad_f00d);
    step(); idle(); step();
    // randomized traffic against a count-based reference
    pend = 0; quiet = 0; errs = 0; fl = 0;
    for (int n = 0; n < 1500; n++) begin
      mset($urandom_range(39) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)), $urandom);
      dn_if.stall = $urandom_range(3) == 0; dn_if.ack = $urandom_range(5) == 0; s_rdat = $urandom;
      #1;
      full = pend == 4;
      e_stall = fl || dn_if.stall || full;
      acc = up_if.cyc && up_if.stb && !e_stall;
      ackok = !fl && dn_if.ack && pend > 0;
      syn = fl && up_if.cyc && pend > 0;
      tm = !fl && up_if.cyc && pend > 0 && !dn_if.ack && quiet == 7;
      chk("rnd_up_ack", 32'(up_if.ack), 32'(ackok || syn));
      chk("rnd_up_stall", 32'(up_if.stall), 32'(e_stall));
      chk("rnd_dn_cyc", 32'(dn_if.cyc), 32'(up_if.cyc && !fl));
      chk("rnd_dn_stb", 32'(dn_if.stb), 32'(up_if.stb && !full && !fl));
      chk("rnd_timeout", 32'(tmo), 32'(tm));
      chk("rnd_errc", 32'(errc), 32'(errs));
      chk("rnd_up_dat", up_rdat, fl ? FILL : s_rdat);
      chk("rnd_dn_adr", dn_if.adr, up_if.adr);
      if (!up_if.cyc) begin
        pend = 0; fl = 0; quiet = 0;
      end else if (fl) begin
        pend--; quiet = 0;
        if (pend == 0) fl = 0;
      end else begin
        quiet = (pend > 0 && !dn_if.ack && !tm) ? quiet + 1 : 0;
        pend = pend + int'(acc) - int'(ackok);
        if (tm) begin
          fl = 1;
          errs = errs < 255 ? errs + 1 : 255;
        end
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
